ram_port_arbiter: RTL and testbench

- Shares one ram_2p port between two hosts, e.g. instruction fetch and debug/DMA on port A.
- Each host speaks the core memory protocol: req/gnt, then in-order rvalid/rdata; writes also return rvalid.
- Arbitrates per cycle and tracks up to MaxOutstanding in-flight transactions in an ID FIFO.
- Routes each dev_rvalid_i/rdata back to the host that issued the request, tolerating the RAM's variable read latency.

---
 rtl/ram_port_arbiter.sv | 119 +++++++++++
 tb/tb_ram_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-host arbiter for one RAM port with in-order response routing
module ram_port_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          FixedPriority  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        h0_req_i,
    output logic        h0_gnt_o,
    input  logic        h0_we_i,
    input  logic [3:0]  h0_be_i,
    input  logic [31:0] h0_addr_i,
    input  logic [31:0] h0_wdata_i,
    output logic        h0_rvalid_o,
    output logic [31:0] h0_rdata_o,
    input  logic        h1_req_i,
    output logic        h1_gnt_o,
    input  logic        h1_we_i,
    input  logic [3:0]  h1_be_i,
    input  logic [31:0] h1_addr_i,
    input  logic [31:0] h1_wdata_i,
    output logic        h1_rvalid_o,
    output logic [31:0] h1_rdata_o,
    output logic        dev_req_o,
    output logic        dev_we_o,
    output logic [3:0]  dev_be_o,
    output logic [31:0] dev_addr_o,
    output logic [31:0] dev_wdata_o,
    input  logic        dev_rvalid_i,
    input  logic [31:0] dev_rdata_i,
    output logic [3:0]  outstanding_o,
    output logic        unexpected_rsp_o
);

    localparam int unsigned     PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
    localparam logic [3:0]      MaxCnt  = 4'(MaxOutstanding);

    logic                      prio_q, prio_d;
    logic [3:0]                count_q, count_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [MaxOutstanding-1:0] id_q, id_d;
    logic                      unexp_q, unexp_d;

    logic can_accept;
    logic fifo_empty;
    logic winner;
    logic grant;
    logic pop;
    logic head_id;

    // Fullness comes from the count, so pointer equality never needs disambiguation.
    always_comb begin
        can_accept = (count_q < MaxCnt);
        fifo_empty = (count_q == 4'd0);
        winner     = h1_req_i & (~h0_req_i | (~FixedPriority & prio_q));
        grant      = (h0_req_i | h1_req_i) & can_accept;
        pop        = dev_rvalid_i & ~fifo_empty;
        head_id    = id_q[rd_ptr_q];
    end

    always_comb begin
        h0_gnt_o         = grant & ~winner;
        h1_gnt_o         = grant & winner;
        dev_req_o        = grant;
        dev_we_o         = grant & (winner ? h1_we_i : h0_we_i);
        dev_be_o         = grant ? (winner ? h1_be_i    : h0_be_i)    : 4'd0;
        dev_addr_o       = grant ? (winner ? h1_addr_i  : h0_addr_i)  : 32'd0;
        dev_wdata_o      = grant ? (winner ? h1_wdata_i : h0_wdata_i) : 32'd0;
        h0_rvalid_o      = pop & ~head_id;
        h1_rvalid_o      = pop & head_id;
        h0_rdata_o       = dev_rdata_i;
        h1_rdata_o       = dev_rdata_i;
        outstanding_o    = count_q;
        unexpected_rsp_o = unexp_q;
    end

    always_comb begin
        prio_d   = prio_q;
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        unexp_d  = unexp_q | (dev_rvalid_i & fifo_empty);
        if (grant) begin
            prio_d         = ~winner;
            id_d[wr_ptr_q] = winner;
            wr_ptr_d       = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({grant, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q   <= 1'b0;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
            unexp_q  <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            unexp_q  <= unexp_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed bench for ram_port_arbiter with a small RAM model
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        h0_req, h0_we, h1_req, h1_we;
    logic [3:0]  h0_be, h1_be;
    logic [31:0] h0_addr, h0_wdata, h1_addr, h1_wdata;
    logic        dev_rvalid;
    logic [31:0] dev_rdata;
    logic        use8;

    logic        a_h0_gnt, a_h1_gnt, a_h0_rv, a_h1_rv, a_req, a_we, a_unexp;
    logic [31:0] a_h0_rd, a_h1_rd, a_addr, a_wdata;
    logic [3:0]  a_be, a_cnt;
    logic        b_h0_gnt, b_h1_gnt, b_h0_rv, b_h1_rv, b_req, b_we, b_unexp;
    logic [31:0] b_h0_rd, b_h1_rd, b_addr, b_wdata;
    logic [3:0]  b_be, b_cnt;

    ram_port_arbiter #(.MaxOutstanding(2), .FixedPriority(1'b0)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .h0_req_i(h0_req), .h0_gnt_o(a_h0_gnt), .h0_we_i(h0_we), .h0_be_i(h0_be),
        .h0_addr_i(h0_addr), .h0_wdata_i(h0_wdata), .h0_rvalid_o(a_h0_rv), .h0_rdata_o(a_h0_rd),
        .h1_req_i(h1_req), .h1_gnt_o(a_h1_gnt), .h1_we_i(h1_we), .h1_be_i(h1_be),
        .h1_addr_i(h1_addr), .h1_wdata_i(h1_wdata), .h1_rvalid_o(a_h1_rv), .h1_rdata_o(a_h1_rd),
        .dev_req_o(a_req), .dev_we_o(a_we), .dev_be_o(a_be), .dev_addr_o(a_addr),
        .dev_wdata_o(a_wdata), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
        .outstanding_o(a_cnt), .unexpected_rsp_o(a_unexp)
    );

    ram_port_arbiter #(.MaxOutstanding(8), .FixedPriority(1'b0)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .h0_req_i(h0_req), .h0_gnt_o(b_h0_gnt), .h0_we_i(h0_we), .h0_be_i(h0_be),
        .h0_addr_i(h0_addr), .h0_wdata_i(h0_wdata), .h0_rvalid_o(b_h0_rv), .h0_rdata_o(b_h0_rd),
        .h1_req_i(h1_req), .h1_gnt_o(b_h1_gnt), .h1_we_i(h1_we), .h1_be_i(h1_be),
        .h1_addr_i(h1_addr), .h1_wdata_i(h1_wdata), .h1_rvalid_o(b_h1_rv), .h1_rdata_o(b_h1_rd),
        .dev_req_o(b_req), .dev_we_o(b_we), .dev_be_o(b_be), .dev_addr_o(b_addr),
        .dev_wdata_o(b_wdata), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
        .outstanding_o(b_cnt), .unexpected_rsp_o(b_unexp)
    );

    // Observed instance: the depth-8 one only for the round-robin case
    logic        m_h0_gnt, m_h1_gnt, m_h0_rv, m_h1_rv, m_req, m_we, m_unexp;
    logic [31:0] m_h0_rd, m_h1_rd, m_addr, m_wdata;
    logic [3:0]  m_be, m_cnt;
    assign m_h0_gnt = use8 ? b_h0_gnt : a_h0_gnt;
    assign m_h1_gnt = use8 ? b_h1_gnt : a_h1_gnt;
    assign m_h0_rv  = use8 ? b_h0_rv  : a_h0_rv;
    assign m_h1_rv  = use8 ? b_h1_rv  : a_h1_rv;
    assign m_h0_rd  = use8 ? b_h0_rd  : a_h0_rd;
    assign m_h1_rd  = use8 ? b_h1_rd  : a_h1_rd;
    assign m_req    = use8 ? b_req    : a_req;
    assign m_we     = use8 ? b_we     : a_we;
    assign m_be     = use8 ? b_be     : a_be;
    assign m_addr   = use8 ? b_addr   : a_addr;
    assign m_wdata  = use8 ? b_wdata  : a_wdata;
    assign m_cnt    = use8 ? b_cnt    : a_cnt;
    assign m_unexp  = use8 ? b_unexp  : a_unexp;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [31:0] mem [0:255];
    int          cyc;
    int          ram_delay;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic hosts_idle();
        h0_req = 0; h0_we = 0; h0_be = 4'hF; h0_addr = 0; h0_wdata = 0;
        h1_req = 0; h1_we = 0; h1_be = 4'hF; h1_addr = 0; h1_wdata = 0;
    endtask

    // Called at the negedge: capture the RAM request, advance to just after the next posedge
    task automatic next_cycle();
        rsp_t        r;
        logic [31:0] d;
        if (m_req) begin
            d = mem[m_addr[9:2]];
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) d[8*b +: 8] = m_wdata[8*b +: 8];
                mem[m_addr[9:2]] = d;
            end
            r.due  = cyc + ram_delay;
            r.data = d;
            rsp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
        dev_rvalid = 0;
        dev_rdata  = 0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            dev_rvalid = 1;
            dev_rdata  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
    endtask

    task automatic do_reset(input bit keep_q);
        hosts_idle();
        rst_n = 0;
        if (!keep_q) begin
            rsp_q.delete();
            dev_rvalid = 0;
            dev_rdata  = 0;
        end
        @(negedge clk);
        next_cycle();
        rst_n = 1;
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0; ram_delay = 4; use8 = 0;
        rst_n = 0; dev_rvalid = 0; dev_rdata = 0;
        hosts_idle();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]  = 32'hA5A5_0001;
        mem[8]  = 32'h1234_5678;
        mem[16] = 32'h4000_0040;
        mem[32] = 32'h8000_0080;

        // reset state
        @(negedge clk);
        chk("rst_cnt", m_cnt, 0);
        chk("rst_unexp", m_unexp, 0);
        chk("rst_devreq", m_req, 0);
        chk("rst_h0gnt", m_h0_gnt, 0);
        next_cycle();
        rst_n = 1;

        // single read
        use8 = 0; ram_delay = 4; do_reset(0);
        h0_req = 1; h0_addr = 32'h10;
        @(negedge clk);
        chk("t1_h0gnt", m_h0_gnt, 1);
        chk("t1_h1gnt", m_h1_gnt, 0);
        chk("t1_addr", m_addr, 32'h10);
        chk("t1_we", m_we, 0);
        next_cycle();
        hosts_idle();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_h0rv", m_h0_rv, k == 4);
            chk("t1_h1rv", m_h1_rv, 0);
            chk("t1_cnt", m_cnt, (k <= 4) ? 1 : 0);
            if (k == 4) chk("t1_rdata", m_h0_rd, 32'hA5A5_0001);
            next_cycle();
        end

        // round-robin contention on the depth-8 instance
        use8 = 1; ram_delay = 2; do_reset(0);
        h0_addr = 32'h40; h1_addr = 32'h80;
        for (int k = 0; k < 10; k++) begin
            h0_req = (k < 6); h1_req = (k < 6);
            @(negedge clk);
            if (k < 6) begin
                chk("t2_h0gnt", m_h0_gnt, (k % 2) == 0);
                chk("t2_h1gnt", m_h1_gnt, (k % 2) == 1);
            end
            chk("t2_h0rv", m_h0_rv, (k >= 2) && (k <= 7) && ((k % 2) == 0));
            chk("t2_h1rv", m_h1_rv, (k >= 2) && (k <= 7) && ((k % 2) == 1));
            if (k >= 2 && k <= 7) begin
                if ((k % 2) == 0) chk("t2_h0rd", m_h0_rd, 32'h4000_0040);
                else              chk("t2_h1rd", m_h1_rd, 32'h8000_0080);
            end
            if (k == 9) chk("t2_cnt", m_cnt, 0);
            next_cycle();
        end

        // outstanding limit with depth 2
        use8 = 0; ram_delay = 4; do_reset(0);
        n = 0;
        for (int k = 0; k <= 10; k++) begin
            h1_req  = (n < 3);
            h1_addr = 32'h30 + 32'(4 * n);
            @(negedge clk);
            chk("t3_h1gnt", m_h1_gnt, (k == 0) || (k == 1) || (k == 5));
            chk("t3_h1rv", m_h1_rv, (k == 4) || (k == 5) || (k == 9));
            chk("t3_h0rv", m_h0_rv, 0);
            if (k >= 2 && k <= 4) chk("t3_cnt2", m_cnt, 2);
            if (k >= 6 && k <= 9) chk("t3_cnt1", m_cnt, 1);
            if (k == 10) chk("t3_cnt0", m_cnt, 0);
            if (k == 0 || k == 1 || k == 5) n++;
            next_cycle();
        end

        // simultaneous grant and response at count 1
        use8 = 0; ram_delay = 2; do_reset(0);
        for (int k = 0; k <= 5; k++) begin
            h0_req = (k == 0); h0_addr = 32'h40;
            h1_req = (k == 2); h1_addr = 32'h80;
            @(negedge clk);
            chk("t4_h0gnt", m_h0_gnt, k == 0);
            chk("t4_h1gnt", m_h1_gnt, k == 2);
            chk("t4_h0rv", m_h0_rv, k == 2);
            chk("t4_h1rv", m_h1_rv, k == 4);
            chk("t4_cnt", m_cnt, (k >= 1 && k <= 4) ? 1 : 0);
            if (k == 4) chk("t4_h1rd", m_h1_rd, 32'h8000_0080);
            next_cycle();
        end

        // write then read of the same word
        use8 = 0; ram_delay = 2; do_reset(0);
        h0_req = 1; h0_we = 1; h0_be = 4'b0011; h0_addr = 32'h20; h0_wdata = 32'hDEAD_BEEF;
        h1_req = 1; h1_we = 0; h1_be = 4'hF;    h1_addr = 32'h20; h1_wdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("t5_h0gnt", m_h0_gnt, 1);
        chk("t5_we", m_we, 1);
        chk("t5_be", m_be, 4'b0011);
        chk("t5_wdata", m_wdata, 32'hDEAD_BEEF);
        next_cycle();
        h0_req = 0; h0_we = 0;
        @(negedge clk);
        chk("t5_h1gnt", m_h1_gnt, 1);
        chk("t5_we1", m_we, 0);
        chk("t5_wdata1", m_wdata, 32'h5555_AAAA);
        next_cycle();
        h1_req = 0;
        @(negedge clk);
        chk("t5_idle_req", m_req, 0);
        chk("t5_idle_addr", m_addr, 0);
        chk("t5_idle_wdata", m_wdata, 0);
        chk("t5_h0rv", m_h0_rv, 1);
        chk("t5_h1rv0", m_h1_rv, 0);
        next_cycle();
        @(negedge clk);
        chk("t5_h1rv", m_h1_rv, 1);
        chk("t5_h1rd", m_h1_rd, 32'h1234_BEEF);
        chk("t5_unexp", m_unexp, 0);
        next_cycle();

        // reset with two reads in flight, then late responses
        use8 = 0; ram_delay = 4; do_reset(0);
        h0_req = 1; h0_addr = 32'h10; h1_req = 1; h1_addr = 32'h40;
        @(negedge clk);
        next_cycle();
        h0_req = 0;
        @(negedge clk);
        next_cycle();
        hosts_idle();
        @(negedge clk);
        chk("t6_cnt_pre", m_cnt, 2);
        rst_n = 0;
        #1;
        chk("t6_cnt_rst", m_cnt, 0);
        chk("t6_unexp_rst", m_unexp, 0);
        next_cycle();
        rst_n = 1;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            chk("t6_h0rv", m_h0_rv, 0);
            chk("t6_h1rv", m_h1_rv, 0);
            chk("t6_cnt", m_cnt, 0);
            chk("t6_unexp", m_unexp, k >= 5);
            next_cycle();
        end
        do_reset(0);
        @(negedge clk);
        chk("t6_unexp_clr", m_unexp, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
